// File: rtl/mem_arbiter_if.sv
// Bundle of IF/MEM request ports and the byte-wide RAM port around mem_arbiter.
// The slave modport is the arbiter; master is the requesters plus RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_wr, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a byte-wide RAM between instruction fetch and the load/store unit,
// serialising 1/2/4-byte little-endian accesses into byte cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [1:0]        last, last_n;
  logic              gnt_mem, gnt_mem_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [31:0]       wdata, wdata_n;
  logic [31:0]       acc, acc_n;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_n;
  logic              ram_wr_q, ram_wr_n;
  logic [7:0]        ram_dout_q, ram_dout_n;
  logic              if_done_q, if_done_n;
  logic [31:0]       if_data_q, if_data_n;
  logic              mem_done_q, mem_done_n;
  logic [31:0]       mem_rdata_q, mem_rdata_n;
  logic              busy_q, busy_n;
  logic [1:0]        cap_idx;

  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= '0;
      gnt_mem     <= 1'b0;
      base        <= '0;
      wdata       <= '0;
      acc         <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      gnt_mem     <= gnt_mem_n;
      base        <= base_n;
      wdata       <= wdata_n;
      acc         <= acc_n;
      ram_addr_q  <= ram_addr_n;
      ram_wr_q    <= ram_wr_n;
      ram_dout_q  <= ram_dout_n;
      if_done_q   <= if_done_n;
      if_data_q   <= if_data_n;
      mem_done_q  <= mem_done_n;
      mem_rdata_q <= mem_rdata_n;
      busy_q      <= busy_n;
    end
  end

  // Each output is computed one cycle ahead so it appears registered in the named state
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    gnt_mem_n   = gnt_mem;
    base_n      = base;
    wdata_n     = wdata;
    acc_n       = acc;
    ram_addr_n  = ram_addr_q;
    ram_wr_n    = 1'b0;
    ram_dout_n  = '0;
    if_done_n   = 1'b0;
    if_data_n   = if_data_q;
    mem_done_n  = 1'b0;
    mem_rdata_n = mem_rdata_q;
    cap_idx     = 2'(cnt - 2'd1);

    case (state)
      IDLE: begin
        if (bus.mem_req) begin
          gnt_mem_n  = 1'b1;
          base_n     = bus.mem_addr;
          wdata_n    = bus.mem_wdata;
          last_n     = last_idx(bus.mem_len);
          cnt_n      = '0;
          acc_n      = '0;
          ram_addr_n = bus.mem_addr;
          if (bus.mem_wr) begin
            state_n    = WR;
            ram_wr_n   = 1'b1;
            ram_dout_n = bus.mem_wdata[7:0];
          end else begin
            state_n = RD;
          end
        end else if (bus.if_req) begin
          gnt_mem_n  = 1'b0;
          base_n     = bus.if_addr;
          wdata_n    = '0;
          last_n     = 2'd3;
          cnt_n      = '0;
          acc_n      = '0;
          ram_addr_n = bus.if_addr;
          state_n    = RD;
        end
      end

      // ram_din lags the address by one cycle, so byte cnt-1 is captured here
      RD: begin
        if (cnt != 2'd0) acc_n[{cap_idx, 3'b000} +: 8] = bus.ram_din;
        if (cnt == last) begin
          state_n = RD_LAST;
        end else begin
          cnt_n      = 2'(cnt + 2'd1);
          ram_addr_n = base + ADDR_W'(cnt_n);
        end
      end

      RD_LAST: begin
        acc_n[{cnt, 3'b000} +: 8] = bus.ram_din;
        state_n = DONE;
        if (gnt_mem) begin
          mem_done_n  = 1'b1;
          mem_rdata_n = acc_n;
        end else begin
          if_done_n = 1'b1;
          if_data_n = acc_n;
        end
      end

      WR: begin
        if (cnt == last) begin
          state_n    = DONE;
          mem_done_n = 1'b1;
        end else begin
          cnt_n      = 2'(cnt + 2'd1);
          ram_addr_n = base + ADDR_W'(cnt_n);
          ram_wr_n   = 1'b1;
          ram_dout_n = wdata[{cnt_n, 3'b000} +: 8];
        end
      end

      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tasks push expected dones and RAM writes,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  done_t if_q[$];
  done_t mem_q[$];
  wr_t   wr_q[$];

  logic [7:0]  ram [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous write, read data valid the cycle after the address
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (bus.ram_wr) ram[bus.ram_addr[15:0]] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_addr[15:0]];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_done) begin
        n_cmp++;
        if (mem_q.size() == 0) begin
          n_bad++;
          $display("FAIL mem_done_unexpected: mem_done=1 at cycle %0d, required none", cyc);
        end else begin
          done_t e;
          e = mem_q.pop_front();
          if (bus.if_done !== 1'b0 || cyc != e.cyc || (e.chk_data && bus.mem_rdata !== e.data)) begin
            n_bad++;
            $display("FAIL mem_done: cycle=%0d rdata=%08h if_done=%b, required cycle=%0d rdata=%08h if_done=0",
                     cyc, bus.mem_rdata, bus.if_done, e.cyc, e.data);
          end
        end
      end
      if (bus.if_done) begin
        n_cmp++;
        if (if_q.size() == 0) begin
          n_bad++;
          $display("FAIL if_done_unexpected: if_done=1 at cycle %0d, required none", cyc);
        end else begin
          done_t e;
          e = if_q.pop_front();
          if (bus.mem_done !== 1'b0 || cyc != e.cyc || bus.if_data !== e.data) begin
            n_bad++;
            $display("FAIL if_done: cycle=%0d data=%08h mem_done=%b, required cycle=%0d data=%08h mem_done=0",
                     cyc, bus.if_data, bus.mem_done, e.cyc, e.data);
          end
        end
      end
      if (bus.ram_wr) begin
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL ram_wr_unexpected: addr=%08h dout=%02h at cycle %0d, required no write",
                   bus.ram_addr, bus.ram_dout, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (bus.ram_addr !== w.addr || bus.ram_dout !== w.data) begin
            n_bad++;
            $display("FAIL ram_write: addr=%08h dout=%02h, required addr=%08h dout=%02h",
                     bus.ram_addr, bus.ram_dout, w.addr, w.data);
          end
        end
      end else if (bus.ram_dout !== 8'h00) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ram_dout_idle: dout=%02h with ram_wr=0, required 00", bus.ram_dout);
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  task automatic mem_access(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp, input int lat);
    done_t e;
    bit    seen;
    int    nb;
    @(posedge clk); #1;
    bus.mem_wr = wr; bus.mem_len = len; bus.mem_addr = addr; bus.mem_wdata = wdata;
    bus.mem_req = 1'b1;
    e.data = exp; e.chk_data = !wr; e.cyc = cyc + lat;
    mem_q.push_back(e);
    nb = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    if (wr) for (int k = 0; k < nb; k++) begin
      wr_t w;
      w.addr = addr + 32'(k);
      w.data = wdata[8*k +: 8];
      wr_q.push_back(w);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_done) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL mem_timeout: no mem_done for addr %08h, required within 40 cycles", addr);
    end
    bus.mem_req = 1'b0;
  endtask

  task automatic if_access(input logic [31:0] addr, input logic [31:0] exp, input int lat);
    done_t e;
    bit    seen;
    @(posedge clk); #1;
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    e.data = exp; e.chk_data = 1'b1; e.cyc = cyc + lat;
    if_q.push_back(e);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.if_done) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL if_timeout: no if_done for addr %08h, required within 40 cycles", addr);
    end
    bus.if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pre [0:19];
    logic [15:0] pa [0:19];
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_wr = 1'b0; bus.mem_len = '0;
    bus.mem_addr = '0; bus.mem_wdata = '0;

    pa[0]  = 16'h0100; pre[0]  = 8'h13;  pa[1]  = 16'h0101; pre[1]  = 8'h05;
    pa[2]  = 16'h0102; pre[2]  = 8'h10;  pa[3]  = 16'h0103; pre[3]  = 8'h00;
    pa[4]  = 16'h0000; pre[4]  = 8'h11;  pa[5]  = 16'h0001; pre[5]  = 8'h22;
    pa[6]  = 16'h0002; pre[6]  = 8'h33;  pa[7]  = 16'h0003; pre[7]  = 8'h8C;
    pa[8]  = 16'h0400; pre[8]  = 8'h01;  pa[9]  = 16'h0401; pre[9]  = 8'h02;
    pa[10] = 16'h0402; pre[10] = 8'h03;  pa[11] = 16'h0403; pre[11] = 8'h04;
    pa[12] = 16'h0500; pre[12] = 8'hAA;  pa[13] = 16'h0501; pre[13] = 8'hBB;
    pa[14] = 16'h0502; pre[14] = 8'hCC;  pa[15] = 16'h0503; pre[15] = 8'hDD;
    pa[16] = 16'h3000; pre[16] = 8'h77;  pa[17] = 16'h3001; pre[17] = 8'h77;
    pa[18] = 16'h3002; pre[18] = 8'h77;  pa[19] = 16'h3003; pre[19] = 8'h77;
    for (int i = 0; i < 20; i++) poke(pa[i], pre[i]);

    check("reset_busy",     32'(bus.busy),     32'h0);
    check("reset_ram_wr",   32'(bus.ram_wr),   32'h0);
    check("reset_ram_addr", bus.ram_addr,      32'h0);
    check("reset_dones",    32'({bus.if_done, bus.mem_done}), 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;

    // IF word fetch
    if_access(32'h100, 32'h0010_0513, 6);
    // word write then readback
    mem_access(1'b1, 2'd2, 32'h2000, 32'hDEAD_BEEF, 32'h0, 5);
    mem_access(1'b0, 2'd2, 32'h2000, 32'h0, 32'hDEAD_BEEF, 6);
    // simultaneous requests: MEM wins, IF follows after DONE
    fork
      mem_access(1'b0, 2'd0, 32'h3, 32'h0, 32'h0000_008C, 3);
      if_access(32'h0, 32'h8C33_2211, 10);
    join
    // halfword write across the address wrap, then read it back
    mem_access(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0, 3);
    mem_access(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 4);
    // byte/half reads and len=3 as a word
    mem_access(1'b0, 2'd0, 32'h101, 32'h0, 32'h0000_0005, 3);
    mem_access(1'b0, 2'd1, 32'h102, 32'h0, 32'h0000_0010, 4);
    mem_access(1'b0, 2'd3, 32'h100, 32'h0, 32'h0010_0513, 6);
    // byte write
    mem_access(1'b1, 2'd0, 32'h0501, 32'h0000_0042, 32'h0, 2);
    mem_access(1'b0, 2'd2, 32'h0500, 32'h0, 32'hDDCC_42AA, 6);

    // reset in cycle 3 of a word write: only two bytes land, no done
    begin
      wr_t w;
      @(posedge clk); #1;
      bus.mem_wr = 1'b1; bus.mem_len = 2'd2; bus.mem_addr = 32'h3000;
      bus.mem_wdata = 32'hCAFE_F00D; bus.mem_req = 1'b1;
      w.addr = 32'h3000; w.data = 8'h0D; wr_q.push_back(w);
      w.addr = 32'h3001; w.data = 8'hF0; wr_q.push_back(w);
      repeat (3) @(posedge clk);
      #1;
      check("pre_abort_ram_wr", 32'(bus.ram_wr), 32'h1);
      rst = 1'b1;
      #1;
      check("abort_ram_wr", 32'(bus.ram_wr), 32'h0);
      check("abort_busy",   32'(bus.busy),   32'h0);
      bus.mem_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    mem_access(1'b0, 2'd2, 32'h3000, 32'h0, 32'h7777_F00D, 6);

    // inputs changed mid-read must not disturb the latched access
    fork
      mem_access(1'b0, 2'd2, 32'h400, 32'h0, 32'h0403_0201, 6);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        bus.mem_addr  = 32'h500;
        bus.mem_wdata = 32'hFFFF_FFFF;
        bus.mem_wr    = 1'b1;
      end
    join
    bus.mem_wr = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("left_mem_q", 32'(mem_q.size()), 32'h0);
    check("left_if_q",  32'(if_q.size()),  32'h0);
    check("left_wr_q",  32'(wr_q.size()),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
